// File: rtl/risk_pkg.sv
// Shared definitions for the RISK command sequencer: function codes, field widths,
// the packed command record and the sequencer state encoding.
package risk_pkg;

    localparam int ADDR_W   = 17;
    localparam int STRIDE_W = 16;
    localparam int REG_W    = 5;
    localparam int FUNC_W   = 3;
    localparam int COUNT_W  = 8;
    localparam int HOLD_W   = 8;

    localparam logic [FUNC_W-1:0] FUNC_LOAD  = 3'b000;
    localparam logic [FUNC_W-1:0] FUNC_STORE = 3'b001;
    localparam logic [FUNC_W-1:0] FUNC_IDLE  = 3'b111;

    typedef struct packed {
        logic [FUNC_W-1:0]   func;
        logic [REG_W-1:0]    tile_reg;
        logic [ADDR_W-1:0]   addr;
        logic [ADDR_W-1:0]   step;
        logic [STRIDE_W-1:0] stride_x;
        logic [STRIDE_W-1:0] stride_y;
        logic [COUNT_W-1:0]  count;
    } risk_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_WAIT  = 3'd2,
        ST_FIRE  = 3'd3,
        ST_FIN   = 3'd4
    } risk_state_e;

    // Only load and store reach the datapath; every other code is treated as a no-op.
    function automatic logic func_is_mem(input logic [FUNC_W-1:0] func);
        return (func == FUNC_LOAD) || (func == FUNC_STORE);
    endfunction

endpackage

// File: rtl/risk_cmd_fifo.sv
// Command queue for the sequencer. Full/empty are registered so the producer-side
// ready never depends combinationally on the consumer's pop.
module risk_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      cnt_r;
    logic [AW:0]      cnt_next_s;
    logic             full_r;
    logic             empty_r;
    logic             push_s;
    logic             pop_s;

    assign push_s  = push && !full_r;
    assign pop_s   = pop && !empty_r;
    assign rd_data = mem_r[rd_ptr_r];
    assign full    = full_r;
    assign empty   = empty_r;

    // Occupancy after this cycle's accepted push/pop.
    always_comb begin
        cnt_next_s = cnt_r;
        case ({push_s, pop_s})
            2'b10:   cnt_next_s = cnt_r + (AW+1)'(1);
            2'b01:   cnt_next_s = cnt_r - (AW+1)'(1);
            default: cnt_next_s = cnt_r;
        endcase
    end

    // Storage array; contents are don't-care while the flags say empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy and registered flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            cnt_r   <= cnt_next_s;
            full_r  <= (cnt_next_s == (AW+1)'(DEPTH));
            empty_r <= (cnt_next_s == (AW+1)'(0));
        end
    end

endmodule

// File: rtl/risk_seq.sv
// Command sequencer for the RISK tile datapath: queues load/store commands and
// expands each into per-tile operations with the address hold the strided memory needs.
module risk_seq
    import risk_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int HOLD      = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [FUNC_W-1:0]   cmd_func,
    input  logic [REG_W-1:0]    cmd_reg,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [ADDR_W-1:0]   cmd_step,
    input  logic [STRIDE_W-1:0] cmd_stride_x,
    input  logic [STRIDE_W-1:0] cmd_stride_y,
    input  logic [COUNT_W-1:0]  cmd_count,
    output logic [FUNC_W-1:0]   risk_func,
    output logic [REG_W-1:0]    risk_reg,
    output logic [ADDR_W-1:0]   risk_addr,
    output logic [STRIDE_W-1:0] risk_stride_x,
    output logic [STRIDE_W-1:0] risk_stride_y,
    output logic                busy,
    output logic                done
);

    risk_cmd_t   wr_cmd_s;
    risk_cmd_t   rd_cmd_s;
    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic        pop_s;

    risk_state_e         state_r;
    logic [FUNC_W-1:0]   work_func_r;
    logic [REG_W-1:0]    work_reg_r;
    logic [ADDR_W-1:0]   work_addr_r;
    logic [ADDR_W-1:0]   work_step_r;
    logic [STRIDE_W-1:0] work_stride_x_r;
    logic [STRIDE_W-1:0] work_stride_y_r;
    logic [COUNT_W-1:0]  remaining_r;
    logic [HOLD_W-1:0]   hold_r;
    logic [FUNC_W-1:0]   risk_func_r;
    logic                done_r;

    // Pack the incoming command fields into the queue record.
    always_comb begin
        wr_cmd_s          = '0;
        wr_cmd_s.func     = cmd_func;
        wr_cmd_s.tile_reg = cmd_reg;
        wr_cmd_s.addr     = cmd_addr;
        wr_cmd_s.step     = cmd_step;
        wr_cmd_s.stride_x = cmd_stride_x;
        wr_cmd_s.stride_y = cmd_stride_y;
        wr_cmd_s.count    = cmd_count;
    end

    risk_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .WIDTH ($bits(risk_cmd_t))
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (cmd_valid),
        .pop     (pop_s),
        .wr_data (wr_cmd_s),
        .rd_data (rd_cmd_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign pop_s         = (state_r == ST_IDLE) && !fifo_empty_s;
    assign cmd_ready     = !fifo_full_s;
    assign busy          = !fifo_empty_s || (state_r != ST_IDLE);
    assign done          = done_r;
    assign risk_func     = risk_func_r;
    assign risk_reg      = work_reg_r;
    assign risk_addr     = work_addr_r;
    assign risk_stride_x = work_stride_x_r;
    assign risk_stride_y = work_stride_y_r;

    // Sequencer FSM; output registers are loaded on the transition into the state that shows them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            work_func_r     <= FUNC_IDLE;
            work_reg_r      <= '0;
            work_addr_r     <= '0;
            work_step_r     <= '0;
            work_stride_x_r <= '0;
            work_stride_y_r <= '0;
            remaining_r     <= '0;
            hold_r          <= '0;
            risk_func_r     <= FUNC_IDLE;
            done_r          <= 1'b0;
        end else begin
            risk_func_r <= FUNC_IDLE;
            done_r      <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        work_func_r     <= rd_cmd_s.func;
                        work_reg_r      <= rd_cmd_s.tile_reg;
                        work_addr_r     <= rd_cmd_s.addr;
                        work_step_r     <= rd_cmd_s.step;
                        work_stride_x_r <= rd_cmd_s.stride_x;
                        work_stride_y_r <= rd_cmd_s.stride_y;
                        remaining_r     <= rd_cmd_s.count;
                        if ((rd_cmd_s.count == 8'd0) || !func_is_mem(rd_cmd_s.func)) begin
                            state_r <= ST_FIN;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_SETUP;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    hold_r <= HOLD_W'(HOLD - 1);
                    if (HOLD == 1) begin
                        state_r     <= ST_FIRE;
                        risk_func_r <= work_func_r;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    hold_r <= hold_r - 8'd1;
                    if (hold_r <= 8'd1) begin
                        state_r     <= ST_FIRE;
                        risk_func_r <= work_func_r;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_FIRE: begin
                    // Address wraps modulo 2^17 by register width.
                    remaining_r <= remaining_r - 8'd1;
                    work_addr_r <= work_addr_r + work_step_r;
                    if (remaining_r == 8'd1) begin
                        state_r <= ST_FIN;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_SETUP;
                    end
                end
                ST_FIN: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_risk_seq.sv
// Directed bench for risk_seq: single load timing, wrapping store, queue back-pressure,
// no-op commands and mid-command reset.
module tb_risk_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_func;
    logic [4:0]  cmd_reg;
    logic [16:0] cmd_addr;
    logic [16:0] cmd_step;
    logic [15:0] cmd_stride_x;
    logic [15:0] cmd_stride_y;
    logic [7:0]  cmd_count;
    logic [2:0]  risk_func;
    logic [4:0]  risk_reg;
    logic [16:0] risk_addr;
    logic [15:0] risk_stride_x;
    logic [15:0] risk_stride_y;
    logic        busy;
    logic        done;

    risk_seq #(.CMD_DEPTH(4), .HOLD(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_func      (cmd_func),
        .cmd_reg       (cmd_reg),
        .cmd_addr      (cmd_addr),
        .cmd_step      (cmd_step),
        .cmd_stride_x  (cmd_stride_x),
        .cmd_stride_y  (cmd_stride_y),
        .cmd_count     (cmd_count),
        .risk_func     (risk_func),
        .risk_reg      (risk_reg),
        .risk_addr     (risk_addr),
        .risk_stride_x (risk_stride_x),
        .risk_stride_y (risk_stride_y),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc;
    int          nf;
    int          nd;
    int          stall_at;
    int          f_cyc  [64];
    logic [2:0]  f_func [64];
    logic [16:0] f_addr [64];
    logic [4:0]  f_reg  [64];
    int          d_cyc  [64];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        cyc = 0;
        nf  = 0;
        nd  = 0;
    endtask

    // Advance one clock and log any datapath op or done pulse seen after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (risk_func != 3'b111 && nf < 64) begin
            f_cyc[nf]  = cyc;
            f_func[nf] = risk_func;
            f_addr[nf] = risk_addr;
            f_reg[nf]  = risk_reg;
            nf++;
        end
        if (done && nd < 64) begin
            d_cyc[nd] = cyc;
            nd++;
        end
    endtask

    task automatic push_cmd(input logic [2:0] f, input logic [4:0] r, input logic [16:0] a,
                            input logic [16:0] s, input logic [7:0] c, input int idx);
        int b;
        cmd_func  = f;
        cmd_reg   = r;
        cmd_addr  = a;
        cmd_step  = s;
        cmd_count = c;
        cmd_valid = 1'b1;
        b = 0;
        while (!cmd_ready && b < 200) begin
            if (stall_at < 0) stall_at = idx;
            tick();
            b++;
        end
        check_eq("push_in_time", 32'(b < 200), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_dones(input int n, input int budget);
        int b;
        b = 0;
        while (nd < n && b < budget) begin
            tick();
            b++;
        end
        check_eq("done_count_reached", 32'(nd), 32'(n));
    endtask

    initial begin
        reset        = 1'b1;
        cmd_valid    = 1'b0;
        cmd_func     = 3'b000;
        cmd_reg      = 5'd0;
        cmd_addr     = 17'd0;
        cmd_step     = 17'd0;
        cmd_stride_x = 16'd0;
        cmd_stride_y = 16'd0;
        cmd_count    = 8'd0;
        stall_at     = -1;
        clear_log();

        #1;
        check_eq("rst_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_func", 32'(risk_func), 32'h7);
        check_eq("rst_addr", 32'(risk_addr), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        tick();
        tick();

        // Single load: op at cycle 4, address from cycle 2, done at cycle 5.
        clear_log();
        cmd_stride_x = 16'h0004;
        cmd_stride_y = 16'h0040;
        push_cmd(3'b000, 5'd1, 17'h00100, 17'h00010, 8'd1, 1);
        check_eq("t1_busy_c1", 32'(busy), 32'd1);
        check_eq("t1_func_c1", 32'(risk_func), 32'h7);
        tick();
        check_eq("t1_addr_c2", 32'(risk_addr), 32'h100);
        check_eq("t1_reg_c2", 32'(risk_reg), 32'd1);
        check_eq("t1_sx_c2", 32'(risk_stride_x), 32'h4);
        check_eq("t1_sy_c2", 32'(risk_stride_y), 32'h40);
        check_eq("t1_func_c2", 32'(risk_func), 32'h7);
        tick();
        check_eq("t1_func_c3", 32'(risk_func), 32'h7);
        tick();
        check_eq("t1_func_c4", 32'(risk_func), 32'h0);
        check_eq("t1_addr_c4", 32'(risk_addr), 32'h100);
        tick();
        check_eq("t1_done_c5", 32'(done), 32'd1);
        check_eq("t1_func_c5", 32'(risk_func), 32'h7);
        tick();
        check_eq("t1_done_c6", 32'(done), 32'd0);
        check_eq("t1_busy_c6", 32'(busy), 32'd0);
        check_eq("t1_nfire", 32'(nf), 32'd1);

        // Store of 3 tiles whose address wraps past 2^17.
        clear_log();
        push_cmd(3'b001, 5'd2, 17'h1FFF8, 17'h00010, 8'd3, 1);
        wait_dones(1, 60);
        repeat (3) tick();
        check_eq("t2_nfire", 32'(nf), 32'd3);
        check_eq("t2_addr0", 32'(f_addr[0]), 32'h1FFF8);
        check_eq("t2_addr1", 32'(f_addr[1]), 32'h00008);
        check_eq("t2_addr2", 32'(f_addr[2]), 32'h00018);
        check_eq("t2_func0", 32'(f_func[0]), 32'h1);
        check_eq("t2_func2", 32'(f_func[2]), 32'h1);
        check_eq("t2_cyc0", 32'(f_cyc[0]), 32'd4);
        check_eq("t2_cyc1", 32'(f_cyc[1]), 32'd7);
        check_eq("t2_cyc2", 32'(f_cyc[2]), 32'd10);
        check_eq("t2_done_cyc", 32'(d_cyc[0]), 32'd11);
        check_eq("t2_ndone", 32'(nd), 32'd1);

        // Six back-to-back 2-tile loads: queue fills after the 5th push (1st already popped).
        clear_log();
        stall_at = -1;
        for (int k = 0; k < 6; k++) begin
            push_cmd(3'b000, 5'(k + 1), 17'(k * 64), 17'h00004, 8'd2, k + 1);
        end
        wait_dones(6, 300);
        check_eq("t3_first_stall", 32'(stall_at), 32'd6);
        check_eq("t3_nfire", 32'(nf), 32'd12);
        for (int k = 0; k < 6; k++) begin
            check_eq("t3_order", 32'(f_reg[2 * k]), 32'(k + 1));
            check_eq("t3_order2", 32'(f_reg[2 * k + 1]), 32'(k + 1));
        end
        for (int k = 0; k < 5; k++) begin
            check_eq("t3_done_gap", 32'(d_cyc[k + 1] - d_cyc[k]), 32'd8);
        end
        tick();
        check_eq("t3_busy_end", 32'(busy), 32'd0);

        // count=0 load and a no-op function: done pulses but nothing reaches the datapath.
        clear_log();
        push_cmd(3'b000, 5'd4, 17'h00200, 17'h00010, 8'd0, 1);
        push_cmd(3'b010, 5'd5, 17'h00300, 17'h00010, 8'd2, 2);
        wait_dones(2, 50);
        repeat (4) tick();
        check_eq("t4_nfire", 32'(nf), 32'd0);
        check_eq("t4_done0", 32'(d_cyc[0]), 32'd2);
        check_eq("t4_done1", 32'(d_cyc[1]), 32'd4);
        check_eq("t4_ndone", 32'(nd), 32'd2);

        // Reset during the WAIT of a 4-tile load with another command still queued.
        clear_log();
        push_cmd(3'b000, 5'd6, 17'h01234, 17'h00010, 8'd4, 1);
        push_cmd(3'b000, 5'd7, 17'h04000, 17'h00010, 8'd1, 2);
        tick();
        check_eq("t5_addr_pre", 32'(risk_addr), 32'h1234);
        check_eq("t5_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("t5_func", 32'(risk_func), 32'h7);
        check_eq("t5_addr", 32'(risk_addr), 32'h0);
        check_eq("t5_reg", 32'(risk_reg), 32'h0);
        check_eq("t5_sx", 32'(risk_stride_x), 32'h0);
        check_eq("t5_busy", 32'(busy), 32'd0);
        check_eq("t5_ready", 32'(cmd_ready), 32'd1);
        #1;
        reset = 1'b0;
        repeat (12) tick();
        check_eq("t5_nfire", 32'(nf), 32'd0);
        check_eq("t5_ndone", 32'(nd), 32'd0);
        check_eq("t5_busy_after", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
